// File: rtl/host_step_clk.sv
// -----------------------------------------------------------------------------
// host_step_clk
//   Single-step host clock generator. Converts a raw, bouncing push-button into
//   exactly one clean clk_host pulse per press so the host system can be
//   advanced one clock at a time. Also counts the pulses issued since reset.
//
//   Optional feature macro: HOST_STEP_AUTO_EN
//     When defined, an auto_run input is added. While auto_run is high the
//     generator free-runs with period 2*PULSE_HIGH_CYCLES.
//
// Ports
//   clk_100MHz  in   1       sole clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   btn_step    in   1       raw asynchronous step button (1 = pressed)
//   auto_run    in   1       free-run request (only with HOST_STEP_AUTO_EN)
//   clk_host    out  1       registered step clock
//   busy        out  1       high while a pulse (high + low phase) is in progress
//   step_count  out  STEP_W  pulses issued since reset, wraps silently
// -----------------------------------------------------------------------------
module host_step_clk #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int PULSE_HIGH_CYCLES = 50_000,
  parameter int STEP_W            = 16
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              btn_step,
`ifdef HOST_STEP_AUTO_EN
  input  logic              auto_run,
`endif
  output logic              clk_host,
  output logic              busy,
  output logic [STEP_W-1:0] step_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_W = $clog2(PULSE_HIGH_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(PULSE_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    LOW      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q, db_prev_d;
  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              clk_host_q, clk_host_d;
  logic              busy_q, busy_d;

  logic              btn_s;
  logic              db_rise;
  logic              auto_go;

`ifdef HOST_STEP_AUTO_EN
  assign auto_go = auto_run;
`else
  assign auto_go = 1'b0;
`endif

  // Two-flop synchronizer: plain register chain, nothing in between.
  assign sync1_d = btn_step;
  assign sync2_d = sync1_q;
  assign btn_s   = sync2_q;

  // Debounce: the accepted level only flips after DEBOUNCE_CYCLES consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_s != db_level_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_level_d = btn_s;
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // db_prev resets to 1 together with db_level, so no false rise after reset.
  assign db_prev_d = db_level_q;
  assign db_rise   = db_level_q & ~db_prev_q;

  // Step FSM: one pulse per debounced press; the button must be seen released
  // (WAIT_REL) before another press is honoured.
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    step_d   = step_q;
    unique case (state_q)
      IDLE: begin
        if (db_rise || auto_go) begin
          state_d  = HIGH;
          ph_cnt_d = '0;
          step_d   = step_q + 1'b1;
        end
      end
      HIGH: begin
        if (ph_cnt_q == PH_MAX) begin
          state_d  = LOW;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (ph_cnt_q == PH_MAX) begin
          ph_cnt_d = '0;
          // Free-running: pass through IDLE in the same cycle and start the
          // next high phase directly, keeping the period at exactly
          // 2*PULSE_HIGH_CYCLES.
          if (auto_go) begin
            state_d = HIGH;
            step_d  = step_q + 1'b1;
          end else begin
            state_d = WAIT_REL;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!db_level_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_REL;
      end
    endcase
  end

  // Outputs are registered copies of the next state, so clk_host is glitch-free.
  always_comb begin
    clk_host_d = (state_d == HIGH);
    busy_d     = (state_d == HIGH) || (state_d == LOW);
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
      db_prev_q  <= 1'b1;
      state_q    <= WAIT_REL;
      ph_cnt_q   <= '0;
      step_q     <= '0;
      clk_host_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      step_q     <= step_d;
      clk_host_q <= clk_host_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_host   = clk_host_q;
  assign busy       = busy_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_host_step_clk.sv
module tb_host_step_clk;

  localparam int DB  = 4;
  localparam int PH  = 3;
  localparam int SW  = 4;

  logic          clk;
  logic          rst;
  logic          btn_step;
  logic          auto_run;
  logic          clk_host;
  logic          busy;
  logic [SW-1:0] step_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int len;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   run = 0;

  host_step_clk #(
    .DEBOUNCE_CYCLES  (DB),
    .PULSE_HIGH_CYCLES(PH),
    .STEP_W           (SW)
  ) dut (
`ifdef HOST_STEP_AUTO_EN
    .auto_run  (auto_run),
`endif
    .clk_100MHz(clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .clk_host  (clk_host),
    .busy      (busy),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int len, input int cnt);
    exp_t e;
    e.len = len;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Scoreboard side: every completed clk_host high run is matched against the
  // oldest expected pulse (length and step_count at its end).
  always @(negedge clk) begin
    if (clk_host === 1'b1) begin
      run++;
    end else if (run != 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse_len", run, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_len", run, e.len);
        chk("pulse_cnt", int'(step_count), e.cnt);
      end
      run = 0;
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    btn_step = 1'b0;
    auto_run = 1'b0;

    // Test 1: single clean press, exact latency and busy width.
    tick(2);
    chk("rst_clk_host", int'(clk_host), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step_count", int'(step_count), 0);
    rst = 1'b0;
    tick(10);
    push(PH, 1);
    btn_step = 1'b1;
    tick(2 + DB);
    chk("t1_before_edge", int'(clk_host), 0);
    tick(1);
    chk("t1_first_high", int'(clk_host), 1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    chk("t1_busy_cycles", n, 2 * PH);
    tick(20 - (2 + DB + 1) - n);
    btn_step = 1'b0;
    tick(10);
    chk("t1_pending", sb.size(), 0);
    chk("t1_step_count", int'(step_count), 1);

    // Test 2: bouncing button never reaches the debounce threshold.
    do_reset();
    tick(10);
    for (int i = 0; i < 8; i++) begin
      btn_step = ~btn_step;
      tick(2);
    end
    btn_step = 1'b0;
    tick(10);
    chk("t2_clk_host", int'(clk_host), 0);
    chk("t2_step_count", int'(step_count), 0);
    chk("t2_pending", sb.size(), 0);

    // Test 3: button held through reset gives no pulse until released.
    btn_step = 1'b1;
    do_reset();
    tick(30);
    chk("t3_held_step", int'(step_count), 0);
    chk("t3_held_clk", int'(clk_host), 0);
    btn_step = 1'b0;
    tick(10);
    push(PH, 1);
    btn_step = 1'b1;
    tick(10);
    btn_step = 1'b0;
    tick(10);
    chk("t3_pending", sb.size(), 0);
    chk("t3_step_count", int'(step_count), 1);

    // Test 4: 16 presses wrap the 4-bit counter back to zero.
    do_reset();
    tick(10);
    for (int i = 0; i < 16; i++) begin
      push(PH, (i + 1) % 16);
      btn_step = 1'b1;
      tick(10);
      btn_step = 1'b0;
      tick(10);
    end
    chk("t4_pending", sb.size(), 0);
    chk("t4_step_wrap", int'(step_count), 0);

    // Test 5: reset in the second high cycle truncates the pulse.
    do_reset();
    tick(10);
    btn_step = 1'b1;
    tick(2 + DB + 1);
    chk("t5_high1", int'(clk_host), 1);
    tick(1);
    chk("t5_high2", int'(clk_host), 1);
    chk("t5_step_before", int'(step_count), 1);
    push(2, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_clk_after_rst", int'(clk_host), 0);
    chk("t5_step_after_rst", int'(step_count), 0);
    chk("t5_busy_after_rst", int'(busy), 0);
    tick(20);
    chk("t5_no_reissue", int'(step_count), 0);
    btn_step = 1'b0;
    tick(10);
    push(PH, 1);
    btn_step = 1'b1;
    tick(10);
    btn_step = 1'b0;
    tick(10);
    chk("t5_pending", sb.size(), 0);
    chk("t5_step_count", int'(step_count), 1);

`ifdef HOST_STEP_AUTO_EN
    // Test 6: free-running mode, period 2*PH.
    do_reset();
    tick(10);
    for (int i = 1; i <= 5; i++) push(PH, i);
    auto_run = 1'b1;
    tick(1);
    chk("t6_first_high", int'(clk_host), 1);
    tick(2 * PH);
    chk("t6_second_high", int'(clk_host), 1);
    chk("t6_step_mid", int'(step_count), 2);
    tick(30 - 1 - 2 * PH);
    auto_run = 1'b0;
    tick(20);
    chk("t6_pending", sb.size(), 0);
    chk("t6_step_count", int'(step_count), 5);
    chk("t6_clk_idle", int'(clk_host), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
